// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (I) and data (D) requesters
// Ports: clk, reset_n (async, active-low)
//   I side: i_req, i_addr -> i_ack, i_rdata, i_err
//   D side: d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata, d_err
//   memory: mem_req, mem_we, mem_addr, mem_wdata <- mem_ready, mem_rdata
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants under contention (default: D beats I).
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(TIMEOUT);
  state_t state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic we_q, we_d, i_ack_q, i_ack_d, i_err_q, i_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic i_ok, d_ok, grant_i, grant_d, expire;
  // a requester's req during its own ack cycle still belongs to the finished transaction
  assign i_ok = i_req & ~i_ack_q;
  assign d_ok = d_req & ~d_ack_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;
  assign grant_d = d_ok & (~i_ok | ~last_d_q);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_d_q <= 1'b1;
    else if (state_q == IDLE && (i_ok | d_ok)) last_d_q <= grant_d;
`else
  assign grant_d = d_ok;
`endif
  assign grant_i = i_ok & ~grant_d;
  // normal completion wins over a simultaneous watchdog expiry
  assign expire = (TIMEOUT != 0) && wdog_q == TMO && !mem_ready;
  assign mem_req   = state_q != IDLE;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q + TIMEOUT_W'(1);
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = d_rdata_q;
    if (state_q == IDLE) begin
      wdog_d = '0;
      if (grant_d) begin
        state_d = BUSY_D;
        addr_d  = d_addr;
        we_d    = d_we;
        wdata_d = d_wdata;
      end else if (grant_i) begin
        state_d = BUSY_I;
        addr_d  = i_addr;
        we_d    = 1'b0;
        wdata_d = '0;
      end
    end else if (mem_ready || expire) begin
      state_d = IDLE;
      if (state_q == BUSY_I) begin
        i_ack_d   = 1'b1;
        i_err_d   = expire;
        i_rdata_d = mem_ready ? mem_rdata : '0;
      end else begin
        d_ack_d   = 1'b1;
        d_err_d   = expire;
        d_rdata_d = (mem_ready && !we_q) ? mem_rdata : '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a transaction-level reference
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic i_ack, i_err, d_ack, d_err, mem_req, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  int total = 0;
  int bad = 0;
  bit busy, cur_d, cur_we, e_iack, e_dack, e_ierr, e_derr, last_d, got_d, exp_d;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, e_irdata, e_drdata;
  int cur_age, n;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    busy = 0; e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0;
    e_irdata = '0; e_drdata = '0; last_d = 1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, " mem_req"}, mem_req, 0);
    check({tag, " mem_we"}, mem_we, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " acks"}, {i_ack, i_err, d_ack, d_err}, 0);
    check({tag, " rdata"}, {i_rdata, d_rdata}, 0);
  endtask
  // One clock: decide from the current inputs what the memory port and both requesters must see
  // after the edge, advance the clock, then compare at the following falling edge.
  task automatic step();
    bit ai, ad, wd;
    ai = i_req && !e_iack;
    ad = d_req && !e_dack;
    e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0;
    if (busy) begin
      if (mem_ready || (TO != 0 && cur_age == TO)) begin
        busy = 0;
        if (cur_d) begin
          e_dack = 1; e_derr = !mem_ready;
          e_drdata = (mem_ready && !cur_we) ? mem_rdata : '0;
        end else begin
          e_iack = 1; e_ierr = !mem_ready;
          e_irdata = mem_ready ? mem_rdata : '0;
        end
      end else cur_age++;
    end else if (ai || ad) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      wd = ad && (!ai || !last_d);
      last_d = wd;
`else
      wd = ad;
`endif
      busy = 1; cur_d = wd; cur_age = 0;
      cur_addr = wd ? d_addr : i_addr;
      cur_we = wd && d_we;
      cur_wdata = d_wdata;
    end
    @(posedge clk);
    @(negedge clk);
    check("mem_req", mem_req, busy);
    if (busy) begin
      check("mem_addr", mem_addr, cur_addr);
      check("mem_we", mem_we, cur_we);
      if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
    end
    check("i_ack", i_ack, e_iack);
    check("i_err", i_err, e_ierr);
    check("i_rdata", i_rdata, e_irdata);
    check("d_ack", d_ack, e_dack);
    check("d_err", d_err, e_derr);
    check("d_rdata", d_rdata, e_drdata);
  endtask
  task automatic drive_rand();
    if (!i_req || e_iack) begin
      i_req = $urandom_range(0, 1) == 1;
      i_addr = $urandom;
    end
    if (!d_req || e_dack) begin
      d_req = $urandom_range(0, 1) == 1;
      d_we = $urandom_range(0, 1) == 1;
      d_addr = $urandom;
      d_wdata = $urandom;
    end
    mem_ready = $urandom_range(0, 3) == 0;
    mem_rdata = $urandom;
  endtask
  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
  endtask
  initial begin
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_zero("reset");
      i_req = $urandom_range(0, 1) == 1; d_req = $urandom_range(0, 1) == 1;
      d_we = $urandom_range(0, 1) == 1; mem_ready = $urandom_range(0, 1) == 1;
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
    end
    @(negedge clk);
    check_zero("reset");
    idle_inputs();
    reset_n = 1;
    repeat (3) step();
    i_req = 1; i_addr = 32'h4;
    step();
    check("fetch mem_req", mem_req, 1);
    check("fetch mem_addr", mem_addr, 32'h4);
    check("fetch mem_we", mem_we, 0);
    step();
    mem_ready = 1; mem_rdata = 32'h13;
    step();
    check("fetch ack", i_ack, 1);
    check("fetch rdata", i_rdata, 32'h13);
    check("fetch err", i_err, 0);
    idle_inputs();
    step();
    i_req = 1; i_addr = 32'h8;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    step();
    check("cont d first addr", mem_addr, 32'h100);
    check("cont d we", mem_we, 1);
    check("cont d wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    step();
    check("cont d_ack", d_ack, 1);
    check("cont store rdata", d_rdata, 0);
    d_req = 0; mem_ready = 0;
    step();
    check("cont i in ack cycle", mem_req, 1);
    check("cont i addr", mem_addr, 32'h8);
    mem_ready = 1;
    step();
    check("cont i_ack", i_ack, 1);
    idle_inputs();
    step();
    for (int r = 0; r < 4; r++) begin
      i_req = 1; i_addr = 32'h200 + r;
      d_req = 1; d_we = 0; d_addr = 32'h300 + r;
      step();
      got_d = mem_addr == d_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (r % 2) == 0;
`else
      exp_d = 1;
`endif
      check($sformatf("grant order %0d", r), got_d, exp_d);
      mem_ready = 1; mem_rdata = $urandom;
      step();
      idle_inputs();
      repeat (2) step();
    end
    d_req = 1; d_we = 0; d_addr = 32'h40;
    step();
    check("timeout busy", mem_req, 1);
    n = 0;
    while (n < 10 && !d_ack) begin
      step();
      n++;
    end
    check("timeout latency", n, 5);
    check("timeout d_err", d_err, 1);
    check("timeout rdata", d_rdata, 0);
    idle_inputs();
    step();
    check("timeout idle", mem_req, 0);
    i_req = 1; i_addr = 32'h20;
    step();
    step();
    #2 reset_n = 0;
    #1 check("async mem_req drop", mem_req, 0);
    mem_ready = 1; mem_rdata = 32'h55;
    @(posedge clk);
    #1 check("no ack in reset", i_ack, 0);
    @(negedge clk);
    check_zero("mid reset");
    idle_inputs();
    reset_n = 1;
    model_reset();
    repeat (3) step();
    for (int c = 0; c < 2000; c++) begin
      drive_rand();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
